muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a  in  32  operand A, the dividend or multiplicand.
REQ-007 SHALL have port b  in  32  operand B, the divisor or multiplier.
REQ-008 SHALL have port flush  in  1  abort any operation in flight; no HI/LO write results.
REQ-009 SHALL have port busy  out  1  high in every state except IDLE.
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port hilo_we  out  1  HI/LO write strobe, equal to done.
REQ-012 SHALL have port hilo_select  out  2  HI/LO write select, constant 2'b00 (write both halves).
REQ-013 SHALL have port hilo_wdata  out  64  result as {HI, LO}.

Function
REQ-014 SHALL implement the states IDLE, MUL, DIV and DONE.
REQ-015 SHALL, in IDLE when start=1 and flush=0, latch a, b and op at that edge; the operation is then accepted.
REQ-016 SHALL, on an accepted op[1]=0, go to MUL; on op[1]=1 with b!=0, go to DIV (counter=0); on op[1]=1 with b==0, go to DONE.
REQ-017 SHALL, in MUL, register the 64-bit product (signed for MULT, unsigned for MULTU) into the result, then go to DONE.
REQ-018 SHALL, in DIV, perform restoring radix-2 division on |A| and |B| (signed ops) or on A and B (unsigned ops), one quotient bit per cycle.
REQ-019 SHALL use 32 DIV cycles, counter 0..31, and go to DONE after count 31.
REQ-020 SHALL, for signed division, negate the quotient when a[31]^b[31] and negate the remainder when a[31], before the result register is written.
REQ-021 SHALL, for DIV, form the result as {remainder, quotient}.
REQ-022 SHALL, for 0x80000000 DIV 0xFFFFFFFF, give quotient 0x80000000 and remainder 0, with no special path.
REQ-023 SHALL, for division by zero (DIV or DIVU), give result {a, 32'hFFFF_FFFF}.
REQ-024 SHALL, in DONE, drive done=hilo_we=1 for exactly one cycle, then go to IDLE.
REQ-025 SHALL drive done/hilo_we combinationally as (state==DONE) & ~flush.
REQ-026 SHALL give latency, counted from the accepting edge: MUL pulse in cycle 2, DIV pulse in cycle 33, divide-by-zero pulse in cycle 1.
REQ-027 SHALL ignore start while busy=1, including in the DONE cycle; no queuing.
REQ-028 SHALL, on flush=1 in any state, go to IDLE at the next edge with the result register unchanged.
REQ-029 SHALL give flush priority over start when both are asserted in the same IDLE cycle.
REQ-030 SHALL register hilo_wdata and hold it until the next completed operation.
REQ-031 SHALL leave hilo_wdata unchanged by an aborted operation.
REQ-032 SHALL not depend on a/b/op after acceptance; changing them mid-operation has no effect.

Reset
REQ-033 SHALL, while rst=0 and regardless of clk, set state=IDLE and counter=0.
REQ-034 SHALL, while rst=0, drive busy=0, done=0, hilo_we=0, hilo_select=00 and hilo_wdata=0.
REQ-035 SHALL, on reset during MUL or DIV, abandon the operation with no hilo_we pulse.
REQ-036 SHALL accept a new start in the first cycle after rst deasserts.

Verification
REQ-037 SHALL cover: MULT a=0xFFFFFFFE, b=3 -> cycle 2 hilo_we=1, hilo_wdata=0xFFFFFFFF_FFFFFFFA; MULTU with the same operands -> 0x00000002_FFFFFFFA.
REQ-038 SHALL cover: DIV a=0xFFFFFFF9, b=2 -> cycle 33 hilo_we=1, hilo_wdata=0xFFFFFFFF_FFFFFFFD; busy=1 in cycles 1..33.
REQ-039 SHALL cover: DIVU a=0x80000000, b=0xFFFFFFFF -> 0x80000000_00000000; DIV with the same operands -> 0x00000000_80000000.
REQ-040 SHALL cover: DIV a=5, b=0 -> cycle 1 hilo_we=1, hilo_wdata=0x00000005_FFFFFFFF.
REQ-041 SHALL cover: DIV started, flush=1 at cycle 10 -> no hilo_we; busy=0 at cycle 11; hilo_wdata unchanged; MULTU 2*3 started at cycle 11 -> 0x00000000_00000006 at cycle 13.
REQ-042 SHALL cover: start pulsed during DIV cycles 5 and 33 -> ignored, exactly one hilo_we; rst=0 at cycle 20 of a DIV -> all outputs 0 immediately, no pulse after release.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle for muldiv_unit.
//   master : drives start, op, a, b and flush; observes busy, done and the HI/LO write port.
//   slave  : the unit itself.
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;          // 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        hilo_we;
  logic [1:0]  hilo_select;
  logic [63:0] hilo_wdata;  // {HI, LO}

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hilo_we, hilo_select, hilo_wdata
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hilo_we, hilo_select, hilo_wdata
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle 32-bit multiply/divide unit writing a 64-bit {HI, LO} result.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : muldiv_unit_if.slave -- start/op/a/b/flush in; busy/done/hilo_* out
// MULT/MULTU take one compute cycle, DIV/DIVU run a 32-step restoring divider, and
// division by zero completes directly with {a, 32'hFFFF_FFFF}.
module muldiv_unit (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // opa holds the multiplicand, or the dividend that shifts out while quotient bits shift in.
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] rem_q, rem_d;
  logic        sgn_q, sgn_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] res_q, res_d;

  logic        op_signed;
  logic [31:0] abs_a, abs_b;
  logic [32:0] trial, diff;
  logic [31:0] quo_next, rem_next, quo_fin, rem_fin;
  logic [63:0] mul_a, mul_b, prod;

  always_comb begin
    op_signed = ~bus.op[0];
    abs_a     = (op_signed && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    abs_b     = (op_signed && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

    // Partial remainder is always below the divisor, so a borrow out of bit 32 means
    // the trial subtraction failed.
    trial    = {rem_q, opa_q[31]};
    diff     = trial - {1'b0, opb_q};
    quo_next = {opa_q[30:0], ~diff[32]};
    rem_next = diff[32] ? trial[31:0] : diff[31:0];
    quo_fin  = neg_quo_q ? (32'd0 - quo_next) : quo_next;
    rem_fin  = neg_rem_q ? (32'd0 - rem_next) : rem_next;

    mul_a = sgn_q ? {{32{opa_q[31]}}, opa_q} : {32'd0, opa_q};
    mul_b = sgn_q ? {{32{opb_q[31]}}, opb_q} : {32'd0, opb_q};
    prod  = mul_a * mul_b;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    sgn_d     = sgn_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_d     = res_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sgn_d     = op_signed;
          neg_quo_d = op_signed & (bus.a[31] ^ bus.b[31]);
          neg_rem_d = op_signed & bus.a[31];
          rem_d     = 32'd0;
          cnt_d     = 5'd0;
          if (!bus.op[1]) begin
            opa_d   = bus.a;
            opb_d   = bus.b;
            state_d = StMul;
          end else if (bus.b == 32'd0) begin
            res_d   = {bus.a, 32'hFFFF_FFFF};
            state_d = StDone;
          end else begin
            opa_d   = abs_a;
            opb_d   = abs_b;
            state_d = StDiv;
          end
        end
      end
      StMul: begin
        res_d   = prod;
        state_d = StDone;
      end
      StDiv: begin
        opa_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          res_d   = {rem_fin, quo_fin};
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flush wins over everything, including a start in the same idle cycle.
    if (bus.flush) begin
      state_d = StIdle;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      rem_q     <= 32'd0;
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= 64'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      sgn_q     <= sgn_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      res_q     <= res_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone) & ~bus.flush;
  assign bus.hilo_we     = bus.done;
  assign bus.hilo_select = 2'b00;
  assign bus.hilo_wdata  = res_q;

endmodule
